// File: rtl/ex_issue_stage_pkg.sv
// Shared definitions for the RV32I issue stage: ALU codes, opcodes, operand
// selects and the 75-bit payload carried through the skid buffer.
package ex_issue_stage_pkg;

    localparam int XLEN = 32;

    // ALU operation codes, must track the ALU's decoder
    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_SLL   = 4'b0010;
    localparam logic [3:0] ALU_SLT   = 4'b0011;
    localparam logic [3:0] ALU_SLTU  = 4'b0100;
    localparam logic [3:0] ALU_XOR   = 4'b0101;
    localparam logic [3:0] ALU_SRL   = 4'b0110;
    localparam logic [3:0] ALU_SRA   = 4'b0111;
    localparam logic [3:0] ALU_OR    = 4'b1000;
    localparam logic [3:0] ALU_AND   = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    typedef enum logic [1:0] {
        A_RS1  = 2'd0,
        A_PC   = 2'd1,
        A_ZERO = 2'd2
    } a_sel_t;

    typedef enum logic [1:0] {
        B_RS2  = 2'd0,
        B_IMM  = 2'd1,
        B_FOUR = 2'd2,
        B_ZERO = 2'd3
    } b_sel_t;

    // bit0 = main valid, bit1 = skid valid
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b11
    } buf_state_t;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [3:0]      ctr;
        logic [4:0]      rd;
        logic            we;
        logic            illegal;
    } payload_t;

    // Shared OP / OP-IMM funct3 map; funct7b5 only selects SUB for register ops
    function automatic logic [3:0] funct_to_alu(input logic [2:0] f3,
                                                input logic       f7b5,
                                                input logic       is_reg);
        logic [3:0] c;
        case (f3)
            3'b000:  c = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  c = ALU_SLL;
            3'b010:  c = ALU_SLT;
            3'b011:  c = ALU_SLTU;
            3'b100:  c = ALU_XOR;
            3'b101:  c = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  c = ALU_OR;
            default: c = ALU_AND;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ex_issue_stage_decode.sv
// Combinational opcode/funct decode into ALU code, operand selects, write
// enable and illegal flag.
module ex_decode
    import ex_issue_stage_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [3:0] o_ctr,
    output a_sel_t     o_a_sel,
    output b_sel_t     o_b_sel,
    output logic       o_we,
    output logic       o_illegal
);

    always_comb begin
        o_ctr     = ALU_ADD;
        o_a_sel   = A_ZERO;
        o_b_sel   = B_ZERO;
        o_we      = 1'b0;
        o_illegal = 1'b0;
        case (opcode)
            OPC_OP: begin
                o_ctr   = funct_to_alu(funct3, funct7b5, 1'b1);
                o_a_sel = A_RS1;
                o_b_sel = B_RS2;
                o_we    = 1'b1;
            end
            OPC_OP_IMM: begin
                o_ctr   = funct_to_alu(funct3, funct7b5, 1'b0);
                o_a_sel = A_RS1;
                o_b_sel = B_IMM;
                o_we    = 1'b1;
            end
            OPC_LUI: begin
                o_ctr   = ALU_PASSB;
                o_b_sel = B_IMM;
                o_we    = 1'b1;
            end
            OPC_AUIPC: begin
                o_a_sel = A_PC;
                o_b_sel = B_IMM;
                o_we    = 1'b1;
            end
            // link value pc+4; the target is computed elsewhere
            OPC_JAL, OPC_JALR: begin
                o_a_sel = A_PC;
                o_b_sel = B_FOUR;
                o_we    = 1'b1;
            end
            OPC_BRANCH: begin
                case (funct3)
                    3'b000, 3'b001: begin
                        o_ctr   = ALU_SUB;
                        o_a_sel = A_RS1;
                        o_b_sel = B_RS2;
                    end
                    3'b100, 3'b101: begin
                        o_ctr   = ALU_SLT;
                        o_a_sel = A_RS1;
                        o_b_sel = B_RS2;
                    end
                    3'b110, 3'b111: begin
                        o_ctr   = ALU_SLTU;
                        o_a_sel = A_RS1;
                        o_b_sel = B_RS2;
                    end
                    default: o_illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                o_a_sel = A_RS1;
                o_b_sel = B_IMM;
                o_we    = 1'b1;
            end
            OPC_STORE: begin
                o_a_sel = A_RS1;
                o_b_sel = B_IMM;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ex_issue_stage.sv
// RV32I issue stage: decode, writeback bypass, operand select and a 2-entry
// skid buffer whose main entry drives the ALU inputs directly.
module ex_issue_stage
    import ex_issue_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] imm,
    input  logic [31:0] pc,
    input  logic [4:0]  rd,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_ctr,
    output logic [4:0]  out_rd,
    output logic        out_we,
    output logic        out_illegal
);

    logic [3:0]  w_ctr;
    a_sel_t      w_a_sel;
    b_sel_t      w_b_sel;
    logic        w_we;
    logic        w_illegal;
    logic [31:0] w_rs1;
    logic [31:0] w_rs2;
    payload_t    w_pay;

    buf_state_t  r_state;
    buf_state_t  w_state_nxt;
    payload_t    r_main;
    payload_t    r_skid;
    logic        w_accept;
    logic        w_drain;
    logic        w_ld_main_new;
    logic        w_ld_main_skid;
    logic        w_ld_skid;

    ex_decode u_dec (
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7b5  (funct7b5),
        .o_ctr     (w_ctr),
        .o_a_sel   (w_a_sel),
        .o_b_sel   (w_b_sel),
        .o_we      (w_we),
        .o_illegal (w_illegal)
    );

    // x0 is never forwarded; it always reads as the register-file value
    assign w_rs1 = (wb_we && (wb_rd != 5'd0) && (wb_rd == rs1_addr)) ? wb_data : rs1_data;
    assign w_rs2 = (wb_we && (wb_rd != 5'd0) && (wb_rd == rs2_addr)) ? wb_data : rs2_data;

    always_comb begin
        w_pay = '0;
        case (w_a_sel)
            A_RS1:   w_pay.a = w_rs1;
            A_PC:    w_pay.a = pc;
            default: w_pay.a = 32'd0;
        endcase
        case (w_b_sel)
            B_RS2:   w_pay.b = w_rs2;
            B_IMM:   w_pay.b = imm;
            B_FOUR:  w_pay.b = 32'd4;
            default: w_pay.b = 32'd0;
        endcase
        w_pay.ctr     = w_ctr;
        w_pay.rd      = rd;
        w_pay.we      = w_we && (rd != 5'd0);
        w_pay.illegal = w_illegal;
    end

    // Handshakes only look at registered state, never at out_ready -> in_ready
    assign out_valid = r_state[0];
    assign in_ready  = ~r_state[1];
    assign w_accept  = in_valid && in_ready;
    assign w_drain   = out_valid && out_ready;

    always_comb begin
        w_state_nxt    = r_state;
        w_ld_main_new  = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt   = ST_ONE;
                        w_ld_main_new = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_drain) begin
                        w_ld_main_new = 1'b1;
                    end else if (w_accept) begin
                        w_state_nxt = ST_TWO;
                        w_ld_skid   = 1'b1;
                    end else if (w_drain) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_drain) begin
                        w_state_nxt    = ST_ONE;
                        w_ld_main_skid = 1'b1;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_ld_main_new) begin
                r_main <= w_pay;
            end else if (w_ld_main_skid) begin
                r_main <= r_skid;
            end
            if (w_ld_skid) begin
                r_skid <= w_pay;
            end
        end
    end

    assign alu_a       = r_main.a;
    assign alu_b       = r_main.b;
    assign alu_ctr     = r_main.ctr;
    assign out_rd      = r_main.rd;
    assign out_we      = r_main.we;
    assign out_illegal = r_main.illegal;

endmodule

// File: tb/tb_ex_issue_stage.sv
// Directed bench for ex_issue_stage: decode/bypass vector table followed by
// backpressure, flush and mid-stream reset sequences.
module tb_ex_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic        funct7b5 = 1'b0;
    logic [4:0]  rs1_addr = '0;
    logic [4:0]  rs2_addr = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic [31:0] imm = '0;
    logic [31:0] pc = '0;
    logic [4:0]  rd = '0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctr;
    logic [4:0]  out_rd;
    logic        out_we;
    logic        out_illegal;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ex_issue_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .imm(imm), .pc(pc), .rd(rd),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr),
        .out_rd(out_rd), .out_we(out_we), .out_illegal(out_illegal)
    );

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f7;
        logic [4:0]  ra1;
        logic [31:0] d1;
        logic [4:0]  ra2;
        logic [31:0] d2;
        logic [31:0] im;
        logic [31:0] p;
        logic [4:0]  rdi;
        logic        wbwe;
        logic [4:0]  wbrd;
        logic [31:0] wbd;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [3:0]  ectr;
        logic        ewe;
        logic        eill;
    } vec_t;

    localparam int NV = 27;
    vec_t vt [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic set_lui(input logic [31:0] tag);
        opcode   = 7'b0110111;
        funct3   = 3'd0;
        funct7b5 = 1'b0;
        imm      = tag;
        rd       = 5'd1;
        wb_we    = 1'b0;
    endtask

    initial begin
        logic [31:0] q[$];
        int sent;
        int drained;

        // opc f3 f7 ra1 d1 ra2 d2 imm pc rd wbwe wbrd wbd | a b ctr we ill
        vt[0]  = '{7'h33, 3'd0, 1'b1, 5'd1, 32'd10, 5'd2, 32'd3, 32'd0, 32'd0, 5'd1, 1'b0, 5'd0, 32'd0, 32'd10, 32'd3, 4'h1, 1'b1, 1'b0};
        vt[1]  = '{7'h33, 3'd0, 1'b0, 5'd1, 32'd7, 5'd2, 32'd8, 32'd0, 32'd0, 5'd2, 1'b0, 5'd0, 32'd0, 32'd7, 32'd8, 4'h0, 1'b1, 1'b0};
        vt[2]  = '{7'h33, 3'd4, 1'b0, 5'd1, 32'hF0, 5'd2, 32'h0F, 32'd0, 32'd0, 5'd3, 1'b0, 5'd0, 32'd0, 32'hF0, 32'h0F, 4'h5, 1'b1, 1'b0};
        vt[3]  = '{7'h33, 3'd3, 1'b0, 5'd1, 32'd1, 5'd2, 32'd2, 32'd0, 32'd0, 5'd4, 1'b0, 5'd0, 32'd0, 32'd1, 32'd2, 4'h4, 1'b1, 1'b0};
        vt[4]  = '{7'h33, 3'd6, 1'b0, 5'd1, 32'd1, 5'd2, 32'd2, 32'd0, 32'd0, 5'd5, 1'b0, 5'd0, 32'd0, 32'd1, 32'd2, 4'h8, 1'b1, 1'b0};
        vt[5]  = '{7'h33, 3'd7, 1'b0, 5'd1, 32'd1, 5'd2, 32'd2, 32'd0, 32'd0, 5'd6, 1'b0, 5'd0, 32'd0, 32'd1, 32'd2, 4'h9, 1'b1, 1'b0};
        vt[6]  = '{7'h33, 3'd1, 1'b0, 5'd1, 32'd1, 5'd2, 32'd2, 32'd0, 32'd0, 5'd7, 1'b0, 5'd0, 32'd0, 32'd1, 32'd2, 4'h2, 1'b1, 1'b0};
        vt[7]  = '{7'h33, 3'd5, 1'b0, 5'd1, 32'd1, 5'd2, 32'd2, 32'd0, 32'd0, 5'd8, 1'b0, 5'd0, 32'd0, 32'd1, 32'd2, 4'h6, 1'b1, 1'b0};
        vt[8]  = '{7'h13, 3'd5, 1'b1, 5'd1, 32'h80000000, 5'd2, 32'd9, 32'h404, 32'd0, 5'd9, 1'b0, 5'd0, 32'd0, 32'h80000000, 32'h404, 4'h7, 1'b1, 1'b0};
        vt[9]  = '{7'h13, 3'd0, 1'b1, 5'd1, 32'd5, 5'd2, 32'd9, 32'hFFFFFFFF, 32'd0, 5'd10, 1'b0, 5'd0, 32'd0, 32'd5, 32'hFFFFFFFF, 4'h0, 1'b1, 1'b0};
        vt[10] = '{7'h13, 3'd2, 1'b0, 5'd1, 32'd5, 5'd2, 32'd9, 32'd6, 32'd0, 5'd11, 1'b0, 5'd0, 32'd0, 32'd5, 32'd6, 4'h3, 1'b1, 1'b0};
        vt[11] = '{7'h37, 3'd0, 1'b0, 5'd1, 32'h55, 5'd2, 32'h66, 32'h12345000, 32'h80, 5'd4, 1'b0, 5'd0, 32'd0, 32'd0, 32'h12345000, 4'hA, 1'b1, 1'b0};
        vt[12] = '{7'h17, 3'd0, 1'b0, 5'd1, 32'h55, 5'd2, 32'h66, 32'h2000, 32'h1000, 5'd4, 1'b0, 5'd0, 32'd0, 32'h1000, 32'h2000, 4'h0, 1'b1, 1'b0};
        vt[13] = '{7'h6F, 3'd0, 1'b0, 5'd1, 32'h55, 5'd2, 32'h66, 32'h800, 32'h400, 5'd1, 1'b0, 5'd0, 32'd0, 32'h400, 32'd4, 4'h0, 1'b1, 1'b0};
        vt[14] = '{7'h67, 3'd0, 1'b0, 5'd1, 32'h999, 5'd2, 32'h66, 32'h10, 32'h500, 5'd1, 1'b0, 5'd0, 32'd0, 32'h500, 32'd4, 4'h0, 1'b1, 1'b0};
        vt[15] = '{7'h63, 3'd4, 1'b0, 5'd1, 32'd5, 5'd2, 32'd6, 32'h20, 32'h600, 5'd3, 1'b0, 5'd0, 32'd0, 32'd5, 32'd6, 4'h3, 1'b0, 1'b0};
        vt[16] = '{7'h63, 3'd0, 1'b0, 5'd1, 32'd5, 5'd2, 32'd6, 32'h20, 32'h600, 5'd3, 1'b0, 5'd0, 32'd0, 32'd5, 32'd6, 4'h1, 1'b0, 1'b0};
        vt[17] = '{7'h63, 3'd7, 1'b0, 5'd1, 32'd5, 5'd2, 32'd6, 32'h20, 32'h600, 5'd3, 1'b0, 5'd0, 32'd0, 32'd5, 32'd6, 4'h4, 1'b0, 1'b0};
        vt[18] = '{7'h63, 3'd2, 1'b0, 5'd1, 32'd5, 5'd2, 32'd6, 32'h20, 32'h600, 5'd3, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 4'h0, 1'b0, 1'b1};
        vt[19] = '{7'h03, 3'd2, 1'b0, 5'd1, 32'h100, 5'd2, 32'd6, 32'd8, 32'h0, 5'd5, 1'b0, 5'd0, 32'd0, 32'h100, 32'd8, 4'h0, 1'b1, 1'b0};
        vt[20] = '{7'h23, 3'd2, 1'b0, 5'd1, 32'h200, 5'd2, 32'h33, 32'hC, 32'h0, 5'd6, 1'b0, 5'd0, 32'd0, 32'h200, 32'hC, 4'h0, 1'b0, 1'b0};
        vt[21] = '{7'h7F, 3'd0, 1'b0, 5'd1, 32'd1, 5'd2, 32'd2, 32'd3, 32'd4, 5'd7, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 4'h0, 1'b0, 1'b1};
        vt[22] = '{7'h33, 3'd0, 1'b0, 5'd1, 32'd1, 5'd2, 32'd2, 32'd0, 32'd0, 5'd0, 1'b0, 5'd0, 32'd0, 32'd1, 32'd2, 4'h0, 1'b0, 1'b0};
        vt[23] = '{7'h33, 3'd0, 1'b0, 5'd5, 32'h1111, 5'd2, 32'd2, 32'd0, 32'd0, 5'd1, 1'b1, 5'd5, 32'hDEAD, 32'hDEAD, 32'd2, 4'h0, 1'b1, 1'b0};
        vt[24] = '{7'h33, 3'd0, 1'b0, 5'd0, 32'h77, 5'd2, 32'd2, 32'd0, 32'd0, 5'd1, 1'b1, 5'd0, 32'hDEAD, 32'h77, 32'd2, 4'h0, 1'b1, 1'b0};
        vt[25] = '{7'h33, 3'd0, 1'b1, 5'd1, 32'd9, 5'd9, 32'd2, 32'd0, 32'd0, 5'd1, 1'b1, 5'd9, 32'hBEEF, 32'd9, 32'hBEEF, 4'h1, 1'b1, 1'b0};
        vt[26] = '{7'h33, 3'd0, 1'b0, 5'd5, 32'h1234, 5'd2, 32'd2, 32'd0, 32'd0, 5'd1, 1'b0, 5'd5, 32'hDEAD, 32'h1234, 32'd2, 4'h0, 1'b1, 1'b0};

        // reset state while reset is held
        repeat (2) @(negedge clk);
        chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst.alu_a", alu_a, 32'd0);
        chk("rst.alu_b", alu_b, 32'd0);
        chk("rst.alu_ctr", {28'd0, alu_ctr}, 32'd0);
        chk("rst.out_rd", {27'd0, out_rd}, 32'd0);
        chk("rst.out_we", {31'd0, out_we}, 32'd0);
        chk("rst.out_illegal", {31'd0, out_illegal}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // one vector per cycle; results checked one cycle after capture
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            opcode = vt[i].opc; funct3 = vt[i].f3; funct7b5 = vt[i].f7;
            rs1_addr = vt[i].ra1; rs1_data = vt[i].d1;
            rs2_addr = vt[i].ra2; rs2_data = vt[i].d2;
            imm = vt[i].im; pc = vt[i].p; rd = vt[i].rdi;
            wb_we = vt[i].wbwe; wb_rd = vt[i].wbrd; wb_data = vt[i].wbd;
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            wb_we = 1'b0;
            chk($sformatf("v%0d.valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("v%0d.a", i), alu_a, vt[i].ea);
            chk($sformatf("v%0d.b", i), alu_b, vt[i].eb);
            chk($sformatf("v%0d.ctr", i), {28'd0, alu_ctr}, {28'd0, vt[i].ectr});
            chk($sformatf("v%0d.rd", i), {27'd0, out_rd}, {27'd0, vt[i].rdi});
            chk($sformatf("v%0d.we", i), {31'd0, out_we}, {31'd0, vt[i].ewe});
            chk($sformatf("v%0d.illegal", i), {31'd0, out_illegal}, {31'd0, vt[i].eill});
        end
        @(negedge clk);
        chk("drain.out_valid", {31'd0, out_valid}, 32'd0);

        // backpressure: out_ready low for the first cycles, continuous offers
        sent = 0;
        drained = 0;
        for (int c = 0; c < 16; c++) begin
            out_ready = (c >= 4);
            in_valid  = (sent < 6);
            set_lui(32'h100 + sent);
            #1;
            if (c == 2 || c == 3) begin
                chk($sformatf("bp.in_ready.c%0d", c), {31'd0, in_ready}, 32'd0);
                chk($sformatf("bp.hold_valid.c%0d", c), {31'd0, out_valid}, 32'd1);
                chk($sformatf("bp.hold_b.c%0d", c), alu_b, 32'h100);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("bp.extra_entry", alu_b, 32'hFFFFFFFF);
                end else begin
                    chk($sformatf("bp.order%0d", drained), alu_b, q.pop_front());
                    drained++;
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(imm);
                sent++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("bp.drained", drained, 32'd6);
        chk("bp.left", q.size(), 32'd0);

        // flush while full with a simultaneous offer that must be dropped
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_lui(32'hA1);
        @(negedge clk);
        set_lui(32'hA2);
        @(negedge clk);
        chk("fl.full", {31'd0, in_ready}, 32'd0);
        set_lui(32'hA3);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl.out_valid", {31'd0, out_valid}, 32'd0);
        chk("fl.in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("fl.gone.c%0d", c), {31'd0, out_valid}, 32'd0);
        end

        // flush in the same cycle as an offer into an empty buffer
        in_valid = 1'b1;
        set_lui(32'hA4);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl.empty_drop", {31'd0, out_valid}, 32'd0);

        // asynchronous reset with an entry on the outputs
        in_valid = 1'b1;
        set_lui(32'hCAFE);
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("mr.pre_valid", {31'd0, out_valid}, 32'd1);
        chk("mr.pre_b", alu_b, 32'hCAFE);
        #2 rst_n = 1'b0;
        #1;
        chk("mr.out_valid", {31'd0, out_valid}, 32'd0);
        chk("mr.in_ready", {31'd0, in_ready}, 32'd1);
        chk("mr.alu_b", alu_b, 32'd0);
        chk("mr.alu_ctr", {28'd0, alu_ctr}, 32'd0);
        chk("mr.out_rd", {27'd0, out_rd}, 32'd0);
        chk("mr.out_we", {31'd0, out_we}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("mr.after_valid", {31'd0, out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
